smi_arbiter: RTL
================

SMI_ARBITER -- requirements
Module: smi_arbiter

Interface
REQ-001 Parameter: N_REQ, fixed 3, number of SMI requesters; parameterisation beyond 3 is not required.
REQ-002 Parameter: TIMEOUT, default 16384, maximum clk cycles in BUSY before the transaction is aborted.
REQ-003 Port: clk  input  1  single clock for all logic.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: req  input  3  per-requester level request, bit i = requester i.
REQ-006 Port: req_wr  input  3  per-requester operation: 1 write, 0 read.
REQ-007 Port: req_phy_addr  input  15  5 bits per requester, requester i at [5i+4:5i].
REQ-008 Port: req_reg_addr  input  15  5 bits per requester, same packing.
REQ-009 Port: req_wdata  input  48  16 bits per requester, requester i at [16i+15:16i].
REQ-010 Port: grant  output  3  one-hot current owner; 0 when idle.
REQ-011 Port: ack  output  3  one-cycle completion pulse to the owner.
REQ-012 Port: err  output  1  one-cycle pulse with ack when the transaction timed out.
REQ-013 Port: rdata  output  16  last read data; held until the next successful read.
REQ-014 Port: rdata_valid  output  3  one-cycle pulse with ack on a successful read only.
REQ-015 Port: m_write_req, m_read_req  output  1 each  one-cycle start pulses to the SMI engine.
REQ-016 Port: m_phy_addr, m_reg_addr  output  5 each; m_write_data  output  16; all driven from the latched command.
REQ-017 Port: m_read_data  input  16; m_data_valid  input  1; m_done  input  1  engine responses.

Function
REQ-018 FSM states: IDLE, ISSUE, BUSY, RESP, with transitions exactly as in REQ-019 to REQ-022.
REQ-019 IDLE: if any req bit is high, select the winner round-robin starting at pointer ptr (ptr, ptr+1, ptr+2, wrapping mod 3), latch its wr/phy/reg/wdata, set grant, and go to ISSUE; otherwise stay in IDLE.
REQ-020 ISSUE: assert m_write_req (wr=1) or m_read_req (wr=0) for exactly one cycle, never both, then go to BUSY.
REQ-021 BUSY: the timer counts up from 0. On m_done go to RESP with err_flag=0. On timer==TIMEOUT-1 without m_done, go to RESP with err_flag=1. If m_done and timeout coincide, m_done wins.
REQ-022 RESP: pulse ack[grant] and err=err_flag for one cycle, set ptr to (owner+1) mod 3, clear grant on the next cycle, then go to IDLE.
REQ-023 m_data_valid while BUSY on a read latches m_read_data into rdata. rdata_valid[owner] pulses in RESP only if the operation is a read, err_flag=0 and m_data_valid was seen. m_data_valid outside BUSY is ignored.
REQ-024 m_phy_addr, m_reg_addr and m_write_data remain stable from ISSUE through RESP.
REQ-025 Requesters hold req and command fields until ack. Fields are sampled only at grant. req dropped after grant does not cancel the transaction. req still high after ack is treated as a new request.
REQ-026 Minimum spacing: IDLE to the next ISSUE is 1 cycle, so back-to-back transactions have at least one IDLE cycle between RESP and ISSUE.
REQ-027 m_done outside BUSY is ignored and does not produce an ack.

Reset
REQ-028 While rst_n is low, the block asynchronously resets to: state=IDLE, ptr=0, grant=0, ack=0, err=0, rdata=16'h0000, rdata_valid=0, m_write_req=0, m_read_req=0, m_phy_addr=0, m_reg_addr=0, m_write_data=0, timer=0.
REQ-029 Reset asserted mid-transaction discards the transaction with no ack. The SMI engine shares rst_n and is reset with it.

Verification
REQ-030 Single read: req=3'b010, req_wr=0, phy=1, reg=17; engine returns 16'hAC00 with m_done -> exactly one m_read_req pulse, m_reg_addr=17, ack=3'b010 and rdata_valid=3'b010 for one cycle, rdata=16'hAC00.
REQ-031 Single write: req=3'b001, req_wr=1, reg=0, wdata=16'h1340 -> one m_write_req pulse, m_write_data=16'h1340, ack=3'b001, rdata_valid=0, rdata unchanged.
REQ-032 Fairness: req=3'b111 held continuously for 6 transactions from reset -> grant order 0,1,2,0,1,2.
REQ-033 Timeout: TIMEOUT=64, m_done never asserted -> ack[owner] and err pulse together exactly 64 cycles after entering BUSY; the next request is then served normally.
REQ-034 Coincidence: m_done asserted on the cycle timer==TIMEOUT-1 -> ack with err=0.
REQ-035 Reset mid-BUSY: assert rst_n=0 -> all outputs return to their reset values immediately; after release, the next req=3'b100 is granted first, since ptr=0 and requester 2 is the only one requesting.

Source files
------------

// File: rtl/smi_arbiter.sv
// smi_arbiter
// Round-robin arbiter that lets three requesters share one SMI (MDIO-style)
// management engine. A winner's command is latched at grant time, issued to
// the engine as a one-cycle start pulse, and then tracked until the engine
// reports completion or a timeout expires. Completion is returned to the
// owner as a one-cycle ack, with err on timeout and rdata_valid on a
// successful read.
//
// Ports
//   clk, rst_n        clock and asynchronous active-low reset
//   req               per-requester level request
//   req_wr            per-requester operation (1 write, 0 read)
//   req_phy_addr      5 bits per requester, requester i at [5i+4:5i]
//   req_reg_addr      5 bits per requester, same packing
//   req_wdata         16 bits per requester, requester i at [16i+15:16i]
//   grant             one-hot current owner, 0 when idle
//   ack               one-cycle completion pulse to the owner
//   err               one-cycle pulse with ack when the transaction timed out
//   rdata             last read data, held until the next read
//   rdata_valid       one-cycle pulse with ack on a successful read
//   m_write_req       one-cycle write start pulse to the engine
//   m_read_req        one-cycle read start pulse to the engine
//   m_phy_addr        latched PHY address
//   m_reg_addr        latched register address
//   m_write_data      latched write data
//   m_read_data       read data from the engine
//   m_data_valid      engine read data qualifier
//   m_done            engine completion

module smi_arbiter #(
   parameter int N_REQ   = 3,
   parameter int TIMEOUT = 16384
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req,
   input  logic [N_REQ-1:0]     req_wr,
   input  logic [5*N_REQ-1:0]   req_phy_addr,
   input  logic [5*N_REQ-1:0]   req_reg_addr,
   input  logic [16*N_REQ-1:0]  req_wdata,
   output logic [N_REQ-1:0]     grant,
   output logic [N_REQ-1:0]     ack,
   output logic                 err,
   output logic [15:0]          rdata,
   output logic [N_REQ-1:0]     rdata_valid,
   output logic                 m_write_req,
   output logic                 m_read_req,
   output logic [4:0]           m_phy_addr,
   output logic [4:0]           m_reg_addr,
   output logic [15:0]          m_write_data,
   input  logic [15:0]          m_read_data,
   input  logic                 m_data_valid,
   input  logic                 m_done
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

   state_t          state, state_next;
   logic [1:0]      ptr;
   logic [1:0]      owner;
   logic [1:0]      pick;
   logic            pick_ok;
   logic [1:0]      second;
   logic [1:0]      third;
   logic [TW-1:0]   timer;
   logic            timeout_hit;
   logic            err_flag;
   logic            seen_valid;
   logic            cmd_wr;

   logic [4:0]      phy_in [N_REQ];
   logic [4:0]      reg_in [N_REQ];
   logic [15:0]     wd_in  [N_REQ];

   // Unpack the per-requester command buses so the winner can be indexed.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         phy_in[i] = req_phy_addr[5*i +: 5];
         reg_in[i] = req_reg_addr[5*i +: 5];
         wd_in[i]  = req_wdata[16*i +: 16];
      end
   end

   // Round-robin search order is ptr, ptr+1, ptr+2 (mod 3); the first
   // requester in that order that is asserting req wins.
   always_comb begin
      second  = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
      third   = (second == 2'd2) ? 2'd0 : second + 2'd1;
      pick    = 2'd0;
      pick_ok = 1'b0;
      if (req[ptr]) begin
         pick    = ptr;
         pick_ok = 1'b1;
      end else if (req[second]) begin
         pick    = second;
         pick_ok = 1'b1;
      end else if (req[third]) begin
         pick    = third;
         pick_ok = 1'b1;
      end
   end

   assign timeout_hit = (timer == TW'(TIMEOUT - 1));

   // Next-state logic plus the pulse outputs, which are pure decodes of the
   // ISSUE and RESP states so they last exactly one cycle each.
   always_comb begin
      state_next  = state;
      m_write_req = 1'b0;
      m_read_req  = 1'b0;
      ack         = '0;
      err         = 1'b0;
      rdata_valid = '0;
      case (state)
         IDLE: begin
            if (pick_ok) state_next = ISSUE;
         end
         ISSUE: begin
            m_write_req = cmd_wr;
            m_read_req  = !cmd_wr;
            state_next  = BUSY;
         end
         BUSY: begin
            if (m_done || timeout_hit) state_next = RESP;
         end
         RESP: begin
            ack = grant;
            err = err_flag;
            if (!cmd_wr && !err_flag && seen_valid) rdata_valid = grant;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // State register and the datapath: command latch at grant, BUSY timer,
   // read-data capture, and pointer advance when the owner is released.
   // m_done takes priority over the timeout when both occur together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         ptr          <= 2'd0;
         owner        <= 2'd0;
         grant        <= '0;
         cmd_wr       <= 1'b0;
         m_phy_addr   <= '0;
         m_reg_addr   <= '0;
         m_write_data <= '0;
         timer        <= '0;
         err_flag     <= 1'b0;
         seen_valid   <= 1'b0;
         rdata        <= 16'h0000;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (pick_ok) begin
                  owner        <= pick;
                  grant        <= N_REQ'(1) << pick;
                  cmd_wr       <= req_wr[pick];
                  m_phy_addr   <= phy_in[pick];
                  m_reg_addr   <= reg_in[pick];
                  m_write_data <= wd_in[pick];
                  timer        <= '0;
                  err_flag     <= 1'b0;
                  seen_valid   <= 1'b0;
               end
            end
            BUSY: begin
               timer <= timer + 1'b1;
               if (m_data_valid && !cmd_wr) begin
                  rdata      <= m_read_data;
                  seen_valid <= 1'b1;
               end
               if (m_done) err_flag <= 1'b0;
               else if (timeout_hit) err_flag <= 1'b1;
            end
            RESP: begin
               grant <= '0;
               timer <= '0;
               ptr   <= (owner == 2'd2) ? 2'd0 : owner + 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
